// File: rtl/ir_pkg.sv
// Shared types for the IR line-buffer stream controllers.
// Holds the FSM state encoding and the row-0 edge-handling modes.
package ir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROW0   = 2'd1,
    ST_STREAM = 2'd2
  } ir_state_e;

  localparam int EDGE_ZERO = 0;
  localparam int EDGE_REPL = 1;

endpackage

// File: rtl/ir_raster_counter.sv
// Column/row raster position with end-of-line and end-of-frame flags.
// Position and flags are combinational; the counter advances one pixel per adv pulse.
module ir_raster_counter #(
  parameter int P_ROW_WIDTH  = 256,
  parameter int P_FRAME_ROWS = 192,
  parameter int P_ADDR_WIDTH = 12,
  parameter int P_ROW_BITS   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    adv,
  input  logic                    restart,
  output logic [P_ADDR_WIDTH-1:0] cur_col,
  output logic [P_ROW_BITS-1:0]   cur_row,
  output logic                    is_eol,
  output logic                    is_eof,
  output logic                    at_origin
);

  localparam logic [P_ADDR_WIDTH-1:0] LAST_COL = P_ADDR_WIDTH'(P_ROW_WIDTH - 1);
  localparam logic [P_ROW_BITS-1:0]   LAST_ROW = P_ROW_BITS'(P_FRAME_ROWS - 1);

  logic [P_ADDR_WIDTH-1:0] col_q;
  logic [P_ROW_BITS-1:0]   row_q;

  // A restart makes the current pixel (0,0) in the same cycle it arrives.
  always_comb begin
    cur_col   = restart ? '0 : col_q;
    cur_row   = restart ? '0 : row_q;
    is_eol    = (cur_col == LAST_COL);
    is_eof    = is_eol && (cur_row == LAST_ROW);
    at_origin = (col_q == '0) && (row_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (adv) begin
      if (is_eol) begin
        col_q <= '0;
        row_q <= is_eof ? '0 : cur_row + P_ROW_BITS'(1);
      end else begin
        col_q <= cur_col + P_ADDR_WIDTH'(1);
        row_q <= cur_row;
      end
    end
  end

endmodule

// File: rtl/ir_row_pair_ctrl.sv
// Pairs each raster pixel with the pixel above it via an external single-row buffer.
// Latency 1 cycle in->out; no backpressure, pixels accepted whenever valid.
module ir_row_pair_ctrl
  import ir_pkg::*;
#(
  parameter int P_ROW_WIDTH  = 256,
  parameter int P_FRAME_ROWS = 192,
  parameter int P_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH = 12,
  parameter int P_EDGE_MODE  = EDGE_ZERO
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_sof,
  input  logic                    i_pix_valid,
  input  logic [P_DATA_WIDTH-1:0] i_pix_data,
  output logic [P_ADDR_WIDTH-1:0] o_addra,
  output logic                    o_wea,
  output logic [P_DATA_WIDTH-1:0] o_dina,
  output logic [P_ADDR_WIDTH-1:0] o_addrb,
  output logic                    o_enb,
  input  logic [P_DATA_WIDTH-1:0] i_doutb,
  output logic                    o_valid,
  output logic [P_DATA_WIDTH-1:0] o_cur,
  output logic [P_DATA_WIDTH-1:0] o_above,
  output logic                    o_eol,
  output logic                    o_eof,
  output logic                    o_err
);

  localparam int RW = $clog2(P_FRAME_ROWS);

  ir_state_e state_q, state_d;

  logic                    accept;
  logic                    restart;
  logic                    mid_sof;
  logic [P_ADDR_WIDTH-1:0] cur_col;
  logic [RW-1:0]           cur_row;
  logic                    is_eol;
  logic                    is_eof;
  logic                    at_origin;
  logic                    pix_vld_q;
  logic                    row0_q;
  logic [P_DATA_WIDTH-1:0] above_q;

  // Reset gates acceptance so the read port is quiet while reset is held.
  assign accept  = i_rst_n && i_pix_valid && (i_sof || (state_q != ST_IDLE));
  assign restart = accept && i_sof;
  assign mid_sof = restart && (state_q != ST_IDLE) && !at_origin;

  ir_raster_counter #(
    .P_ROW_WIDTH  (P_ROW_WIDTH),
    .P_FRAME_ROWS (P_FRAME_ROWS),
    .P_ADDR_WIDTH (P_ADDR_WIDTH),
    .P_ROW_BITS   (RW)
  ) u_cnt (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .adv       (accept),
    .restart   (restart),
    .cur_col   (cur_col),
    .cur_row   (cur_row),
    .is_eol    (is_eol),
    .is_eof    (is_eof),
    .at_origin (at_origin)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = ST_ROW0;
    end else if (accept) begin
      unique case (state_q)
        ST_ROW0:   if (is_eol) state_d = ST_STREAM;
        ST_STREAM: if (is_eof) state_d = ST_IDLE;
        default:   state_d = state_q;
      endcase
    end
  end

  // Read this column now; its write lands next cycle, so the read sees the previous row.
  assign o_addrb = cur_col;
  assign o_enb   = accept;
  assign o_wea   = pix_vld_q;
  assign o_valid = pix_vld_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pix_vld_q <= 1'b0;
      o_err     <= 1'b0;
      o_addra   <= '0;
      o_dina    <= '0;
      o_cur     <= '0;
      o_eol     <= 1'b0;
      o_eof     <= 1'b0;
      row0_q    <= 1'b0;
    end else begin
      pix_vld_q <= accept;
      o_err     <= mid_sof;
      if (accept) begin
        o_addra <= cur_col;
        o_dina  <= i_pix_data;
        o_cur   <= i_pix_data;
        o_eol   <= is_eol;
        o_eof   <= is_eof;
        row0_q  <= (cur_row == '0);
      end
    end
  end

  // The buffer output is only meaningful in the pair cycle; hold the last pair otherwise.
  always_comb begin
    o_above = above_q;
    if (pix_vld_q) begin
      if (row0_q) o_above = (P_EDGE_MODE == EDGE_REPL) ? o_cur : '0;
      else        o_above = i_doutb;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       above_q <= '0;
    else if (pix_vld_q) above_q <= o_above;
  end

endmodule
